// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
// Independent watchdog on the signal heads driven by a traffic_light controller.
// Every clock it samples both vehicle heads and both pedestrian heads. It flags
// conflicting greens, encodings that are not one-hot, illegal vehicle sequences,
// yellows that are too short, and a controller that has stopped changing.
// The first fault is latched and flash_en asks the cabinet for all-red flash.
//
// Stall counting: the counter holds the number of consecutive samples that show
// identical heads, counting the first one. A head change, or the first sample
// after reset or clear, restarts it at 1. The stall fault fires on the sample
// where the count reaches MAX_STALL.

module traffic_conflict_monitor #(
  parameter int MIN_YELLOW  = 3,
  parameter int CONF_FILTER = 2,
  parameter int MAX_STALL   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] ns,
  input  logic [2:0] ew,
  input  logic [2:0] p_ns,
  input  logic [2:0] p_ew,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_en,
  output logic [7:0] fault_cnt
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam int CW = $clog2(CONF_FILTER + 1);
  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam int SW = $clog2(MAX_STALL + 1);

  localparam logic [CW-1:0] CONF_MAX  = CW'(CONF_FILTER);
  localparam logic [YW-1:0] Y_MAX     = YW'(MIN_YELLOW);
  localparam logic [SW-1:0] STALL_MAX = SW'(MAX_STALL);

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_VCONF = 3'd1;
  localparam logic [2:0] C_PCONF = 3'd2;
  localparam logic [2:0] C_ENC   = 3'd3;
  localparam logic [2:0] C_TRANS = 3'd4;
  localparam logic [2:0] C_SHORT = 3'd5;
  localparam logic [2:0] C_STALL = 3'd6;

  // A vehicle head may only stay put or advance G->Y, Y->R or R->G.
  function automatic logic legal_step(input logic [2:0] prev, input logic [2:0] cur);
    return (prev == cur) ||
           (prev == GRN && cur == YEL) ||
           (prev == YEL && cur == RED) ||
           (prev == RED && cur == GRN);
  endfunction

  logic [2:0]    ns_q, ew_q, p_ns_q, p_ew_q;
  logic          prev_valid;
  logic [CW-1:0] vcnt, pcnt, vcnt_nxt, pcnt_nxt;
  logic [YW-1:0] ns_y, ew_y, ns_y_nxt, ew_y_nxt;
  logic [SW-1:0] stall, stall_nxt;

  logic       vconf, pconf, badenc, illegal, short_y, changed;
  logic       vconf_hit, pconf_hit, stall_hit, clr_ok;
  logic [2:0] code_nxt;

  assign flash_en = fault;

  // Classify the current sample and work out the next value of every counter.
  always_comb begin
    vconf   = (ns != RED) && (ew != RED);
    pconf   = (p_ns[0] && (ew != RED)) || (p_ew[0] && (ns != RED));
    badenc  = !$onehot(ns) || !$onehot(ew) || !$onehot(p_ns) || !$onehot(p_ew);
    changed = {ns, ew, p_ns, p_ew} != {ns_q, ew_q, p_ns_q, p_ew_q};

    vcnt_nxt = '0;
    if (vconf) vcnt_nxt = (vcnt == CONF_MAX) ? vcnt : vcnt + CW'(1);
    pcnt_nxt = '0;
    if (pconf) pcnt_nxt = (pcnt == CONF_MAX) ? pcnt : pcnt + CW'(1);

    ns_y_nxt = '0;
    if (ns == YEL) ns_y_nxt = (ns_y == Y_MAX) ? ns_y : ns_y + YW'(1);
    ew_y_nxt = '0;
    if (ew == YEL) ew_y_nxt = (ew_y == Y_MAX) ? ew_y : ew_y + YW'(1);

    stall_nxt = SW'(1);
    if (prev_valid && !changed)
      stall_nxt = (stall == STALL_MAX) ? stall : stall + SW'(1);

    illegal = prev_valid && (!legal_step(ns_q, ns) || !legal_step(ew_q, ew));
    short_y = prev_valid &&
              (((ns_q == YEL) && (ns == RED) && (ns_y < Y_MAX)) ||
               ((ew_q == YEL) && (ew == RED) && (ew_y < Y_MAX)));

    vconf_hit = vconf && (vcnt_nxt == CONF_MAX);
    pconf_hit = pconf && (pcnt_nxt == CONF_MAX);
    stall_hit = (stall_nxt == STALL_MAX);

    code_nxt = C_NONE;
    if (vconf_hit)      code_nxt = C_VCONF;
    else if (pconf_hit) code_nxt = C_PCONF;
    else if (badenc)    code_nxt = C_ENC;
    else if (illegal)   code_nxt = C_TRANS;
    else if (short_y)   code_nxt = C_SHORT;
    else if (stall_hit) code_nxt = C_STALL;

    clr_ok = fault && clr_fault && !(vconf || pconf || badenc);
  end

  // Register the sampled heads and counters, latch the first fault, handle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fault      <= 1'b0;
      fault_code <= C_NONE;
      fault_cnt  <= 8'd0;
      prev_valid <= 1'b0;
      vcnt       <= '0;
      pcnt       <= '0;
      ns_y       <= '0;
      ew_y       <= '0;
      stall      <= '0;
      ns_q       <= '0;
      ew_q       <= '0;
      p_ns_q     <= '0;
      p_ew_q     <= '0;
    end else begin
      ns_q   <= ns;
      ew_q   <= ew;
      p_ns_q <= p_ns;
      p_ew_q <= p_ew;
      if (clr_ok) begin
        fault      <= 1'b0;
        fault_code <= C_NONE;
        prev_valid <= 1'b0;
        vcnt       <= '0;
        pcnt       <= '0;
        ns_y       <= '0;
        ew_y       <= '0;
        stall      <= '0;
      end else begin
        prev_valid <= 1'b1;
        vcnt       <= vcnt_nxt;
        pcnt       <= pcnt_nxt;
        ns_y       <= ns_y_nxt;
        ew_y       <= ew_y_nxt;
        stall      <= stall_nxt;
        if (!fault && (code_nxt != C_NONE)) begin
          fault      <= 1'b1;
          fault_code <= code_nxt;
          if (fault_cnt != 8'd255) fault_cnt <= fault_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// tb_traffic_conflict_monitor
// Scripted scenarios drive the heads one sample per clock. Each stimulus pushes
// the outputs expected after that edge into a queue; a monitor pops one entry
// shortly after every rising edge and compares it with the DUT.

module tb_traffic_conflict_monitor;

  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] DW  = 3'b100;
  localparam logic [2:0] FDW = 3'b010;
  localparam logic [2:0] WK  = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] ns = R, ew = R, p_ns = DW, p_ew = DW;
  logic       clr_fault = 1'b0;
  logic       fault, flash_en;
  logic [2:0] fault_code;
  logic [7:0] fault_cnt;

  int         assertions = 0;
  int         failures = 0;
  string      phase = "reset";
  logic [12:0] sb[$];
  logic [7:0] cnt;

  traffic_conflict_monitor #(
    .MIN_YELLOW(3), .CONF_FILTER(2), .MAX_STALL(64)
  ) dut (
    .clk(clk), .rst(rst), .ns(ns), .ew(ew), .p_ns(p_ns), .p_ew(p_ew),
    .clr_fault(clr_fault), .fault(fault), .fault_code(fault_code),
    .flash_en(flash_en), .fault_cnt(fault_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [12:0] got, input logic [12:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got {fault,flash,code,cnt}=%h required %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [2:0] a, input logic [2:0] b,
                               input logic [2:0] c, input logic [2:0] d, input logic clr,
                               input logic ef, input logic [2:0] ec, input logic [7:0] en);
    @(negedge clk);
    rst = r; ns = a; ew = b; p_ns = c; p_ew = d; clr_fault = clr;
    sb.push_back({ef, ef, ec, en});
  endtask

  // Compare the DUT against the oldest expectation just after each edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) checkOutput(phase, {fault, flash_en, fault_code, fault_cnt}, sb.pop_front());
  end

  // Hard stop in case the script never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    $display("[TB] start");
    applyStimulus(0, R, R, DW, DW, 0, 0, 0, 0);
    applyStimulus(0, R, R, DW, DW, 0, 0, 0, 0);

    phase = "legal_cycle";
    for (int p = 0; p < 32; p++) begin
      for (int i = 0; i < 4; i++) applyStimulus(1, G, R, WK, DW, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, Y, R, FDW, DW, 0, 0, 0, 0);
      applyStimulus(1, R, R, DW, DW, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) applyStimulus(1, R, G, DW, WK, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, R, Y, DW, FDW, 0, 0, 0, 0);
      applyStimulus(1, R, R, DW, DW, 0, 0, 0, 0);
    end

    phase = "conf_filter";
    applyStimulus(1, G, R, DW, WK, 0, 0, 0, 0);
    applyStimulus(1, G, R, DW, DW, 0, 0, 0, 0);
    applyStimulus(1, G, G, DW, DW, 0, 0, 0, 0);
    applyStimulus(0, R, R, DW, DW, 0, 0, 0, 0);
    applyStimulus(1, G, G, DW, DW, 0, 0, 0, 0);
    phase = "vconf_fault";
    applyStimulus(1, G, G, DW, DW, 0, 1, 1, 1);
    phase = "clr_in_conflict";
    applyStimulus(1, G, G, DW, DW, 1, 1, 1, 1);
    phase = "clr_vconf";
    applyStimulus(1, R, R, DW, DW, 1, 0, 0, 1);

    phase = "illegal_trans";
    applyStimulus(1, G, R, DW, DW, 0, 0, 0, 1);
    applyStimulus(1, R, R, DW, DW, 0, 1, 4, 2);
    applyStimulus(1, R, R, DW, DW, 1, 0, 0, 2);
    phase = "short_yellow";
    applyStimulus(1, Y, R, DW, DW, 0, 0, 0, 2);
    applyStimulus(1, Y, R, DW, DW, 0, 0, 0, 2);
    applyStimulus(1, R, R, DW, DW, 0, 1, 5, 3);
    applyStimulus(1, R, R, DW, DW, 1, 0, 0, 3);

    phase = "stall";
    for (int i = 1; i < 64; i++) applyStimulus(1, R, R, DW, DW, 0, 0, 0, 3);
    applyStimulus(1, R, R, DW, DW, 0, 1, 6, 4);
    applyStimulus(1, R, R, DW, DW, 0, 1, 6, 4);
    applyStimulus(1, R, R, DW, DW, 1, 0, 0, 4);
    phase = "stall_again";
    for (int i = 1; i < 64; i++) applyStimulus(1, R, R, DW, DW, 0, 0, 0, 4);
    applyStimulus(1, R, R, DW, DW, 0, 1, 6, 5);
    applyStimulus(1, R, R, DW, DW, 1, 0, 0, 5);

    phase = "bad_encoding";
    applyStimulus(1, R, 3'b011, DW, DW, 1, 1, 3, 6);
    applyStimulus(1, R, 3'b011, DW, DW, 1, 1, 3, 6);
    applyStimulus(1, R, R, DW, DW, 1, 0, 0, 6);

    phase = "reset_mid_fault";
    applyStimulus(1, G, R, DW, DW, 0, 0, 0, 6);
    applyStimulus(1, R, R, DW, DW, 0, 1, 4, 7);
    applyStimulus(0, R, R, DW, DW, 0, 0, 0, 0);

    phase = "priority_1_over_3";
    applyStimulus(1, G, G, DW, DW, 0, 0, 0, 0);
    applyStimulus(1, G, 3'b011, DW, DW, 0, 1, 1, 1);
    applyStimulus(1, R, R, DW, DW, 1, 0, 0, 1);

    phase = "ped_conflict";
    applyStimulus(1, G, R, DW, WK, 0, 0, 0, 1);
    applyStimulus(1, G, R, DW, WK, 0, 1, 2, 2);
    applyStimulus(1, R, R, DW, DW, 1, 0, 0, 2);

    phase = "cnt_saturation";
    cnt = 8'd2;
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1, G, R, DW, DW, 0, 0, 0, cnt);
      if (cnt != 8'd255) cnt = cnt + 8'd1;
      applyStimulus(1, R, R, DW, DW, 0, 1, 4, cnt);
      applyStimulus(1, R, R, DW, DW, 1, 0, 0, cnt);
    end

    repeat (2) @(posedge clk);
    #2;
    checkOutput("queue_drained", 13'(sb.size()), 13'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
